// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared state type, exponent limits and default widths
// for the FFT frame sequencer and its source-side monitor.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    localparam int EXP_MIN       = -14;
    localparam int EXP_MAX       = 2;
    localparam int NPTS_LOG2_DEF = 10;
    localparam int DW_DEF        = 16;
    localparam int EW_DEF        = 6;
    localparam int CNT_W         = 16;

    // True when a block exponent is outside what the scaler can apply.
    function automatic logic exp_bad(input int e);
        return (e < EXP_MIN) || (e > EXP_MAX);
    endfunction

endpackage

// File: rtl/fft_src_monitor.sv
// fft_src_monitor: holds the output block exponent for a whole frame,
// flags range/core errors and counts output frames (stats: FFT_CTRL_STATS_EN).
module fft_src_monitor
    import fft_ctrl_pkg::*;
#(
    parameter int EW = EW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             src_valid_i,
    input  logic             src_ready_i,
    input  logic             src_sop_i,
    input  logic             src_eop_i,
    input  logic [EW-1:0]    src_exp_i,
    input  logic [1:0]       src_error_i,
    output logic [EW-1:0]    exp_out_o,
    output logic             exp_range_err_o,
    output logic             err_sticky_o,
    output logic [CNT_W-1:0] outfr_o
`ifdef FFT_CTRL_STATS_EN
    ,
    output logic [31:0]      frame_count_o,
    output logic [EW-1:0]    max_exp_o
`endif
);

    logic          beat;
    logic          sop_beat;
    logic          eop_beat;
    logic [EW-1:0] exp_hold_q, exp_hold_d;
    logic          rng_q, rng_d;
    logic          err_q, err_d;
    logic [CNT_W-1:0] outfr_q, outfr_d;

    assign beat     = src_valid_i & src_ready_i;
    assign sop_beat = beat & src_sop_i;
    assign eop_beat = beat & src_eop_i;

    assign exp_out_o       = (src_valid_i & src_sop_i) ? src_exp_i : exp_hold_q;
    assign exp_range_err_o = rng_q;
    assign err_sticky_o    = err_q;
    assign outfr_o         = outfr_q;

    // Latch the exponent at sop and accumulate sticky flags and frame count.
    always_comb begin
        exp_hold_d = exp_hold_q;
        rng_d      = rng_q;
        err_d      = err_q;
        outfr_d    = outfr_q;
        if (sop_beat) begin
            exp_hold_d = src_exp_i;
        end
        if (clr_i) begin
            rng_d   = 1'b0;
            err_d   = 1'b0;
            outfr_d = '0;
        end else begin
            if (sop_beat && exp_bad(int'($signed(src_exp_i)))) begin
                rng_d = 1'b1;
            end
            if (beat && (src_error_i != 2'd0)) begin
                err_d = 1'b1;
            end
            if (eop_beat) begin
                outfr_d = outfr_q + 16'd1;
            end
        end
    end

    // Monitor state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_hold_q <= '0;
            rng_q      <= 1'b0;
            err_q      <= 1'b0;
            outfr_q    <= '0;
        end else begin
            exp_hold_q <= exp_hold_d;
            rng_q      <= rng_d;
            err_q      <= err_d;
            outfr_q    <= outfr_d;
        end
    end

`ifdef FFT_CTRL_STATS_EN
    localparam logic [EW-1:0] EXP_LOW = {1'b1, {(EW-1){1'b0}}};

    logic [31:0]   fc_q, fc_d;
    logic [EW-1:0] mx_q, mx_d;

    assign frame_count_o = fc_q;
    assign max_exp_o     = mx_q;

    // Saturating output-frame count and signed running max of sop exponents.
    always_comb begin
        fc_d = fc_q;
        mx_d = mx_q;
        if (clr_i) begin
            fc_d = '0;
            mx_d = EXP_LOW;
        end else begin
            if (eop_beat && (fc_q != 32'hFFFF_FFFF)) begin
                fc_d = fc_q + 32'd1;
            end
            if (sop_beat && ($signed(src_exp_i) > $signed(mx_q))) begin
                mx_d = src_exp_i;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fc_q <= '0;
            mx_q <= EXP_LOW;
        end else begin
            fc_q <= fc_d;
            mx_q <= mx_d;
        end
    end
`endif

endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: slices a sample stream into N-point FFT frames and tracks
// output frames until a run drains. Optional stats: FFT_CTRL_STATS_EN.
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int NPTS_LOG2 = NPTS_LOG2_DEF,
    parameter int DW        = DW_DEF,
    parameter int EW        = EW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [15:0]   nframes,
    input  logic          abort,
    input  logic          in_valid,
    input  logic [DW-1:0] in_real,
    input  logic [DW-1:0] in_imag,
    output logic          in_ready,
    output logic          fft_sink_valid,
    output logic          fft_sink_sop,
    output logic          fft_sink_eop,
    output logic [DW-1:0] fft_sink_real,
    output logic [DW-1:0] fft_sink_imag,
    input  logic          fft_sink_ready,
    input  logic          fft_src_valid,
    input  logic          fft_src_sop,
    input  logic          fft_src_eop,
    input  logic [EW-1:0] fft_src_exp,
    input  logic [1:0]    fft_src_error,
    input  logic          src_ready,
    output logic          fft_src_ready,
    output logic [EW-1:0] exp_out,
    output logic          busy,
    output logic          done,
    output logic          err_sticky,
    output logic          exp_range_err
`ifdef FFT_CTRL_STATS_EN
    ,
    output logic [31:0]   frame_count,
    output logic [EW-1:0] max_exp
`endif
);

    localparam logic [NPTS_LOG2-1:0] SCNT_ONE  = 1;
    localparam logic [NPTS_LOG2-1:0] SCNT_LAST = '1;

    state_e                 state_q, state_d;
    logic [NPTS_LOG2-1:0]   scnt_q, scnt_d;
    logic [CNT_W-1:0]       infr_q, infr_d;
    logic [CNT_W-1:0]       nfr_q, nfr_d;
    logic                   abort_q, abort_d;
    logic [CNT_W-1:0]       outfr;
    logic                   run;
    logic                   acc;
    logic                   first;
    logic                   last;
    logic                   fin_fr;
    logic                   stop;
    logic                   clr;

    assign run    = (state_q == RUN);
    assign in_ready       = fft_sink_ready & run;
    assign fft_sink_valid = in_valid & run;
    assign fft_sink_real  = in_real;
    assign fft_sink_imag  = in_imag;
    assign acc    = in_valid & in_ready;
    assign first  = (scnt_q == '0);
    assign last   = (scnt_q == SCNT_LAST);
    assign fft_sink_sop = run & first;
    assign fft_sink_eop = run & last;
    assign fin_fr = (nfr_q != '0) && ((infr_q + 16'd1) == nfr_q);
    assign stop   = abort_q | abort;
    assign busy   = (state_q != IDLE);
    assign fft_src_ready = src_ready;

    // Run sequencer: frame-boundary exits to DRAIN, DRAIN waits for outputs.
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        infr_d  = infr_q;
        nfr_d   = nfr_q;
        abort_d = abort_q;
        clr     = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    clr     = 1'b1;
                    scnt_d  = '0;
                    infr_d  = '0;
                    nfr_d   = nframes;
                    abort_d = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    abort_d = 1'b1;
                end
                if (acc) begin
                    scnt_d = scnt_q + SCNT_ONE;
                    if (last) begin
                        infr_d = infr_q + 16'd1;
                        if (fin_fr || stop) begin
                            state_d = DRAIN;
                        end
                    end
                end else if (first && stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (outfr == infr_q) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer and sink-side counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            scnt_q  <= '0;
            infr_q  <= '0;
            nfr_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            infr_q  <= infr_d;
            nfr_q   <= nfr_d;
            abort_q <= abort_d;
        end
    end

    fft_src_monitor #(
        .EW(EW)
    ) u_mon (
        .clk             (clk),
        .reset           (reset),
        .clr_i           (clr),
        .src_valid_i     (fft_src_valid),
        .src_ready_i     (src_ready),
        .src_sop_i       (fft_src_sop),
        .src_eop_i       (fft_src_eop),
        .src_exp_i       (fft_src_exp),
        .src_error_i     (fft_src_error),
        .exp_out_o       (exp_out),
        .exp_range_err_o (exp_range_err),
        .err_sticky_o    (err_sticky),
        .outfr_o         (outfr)
`ifdef FFT_CTRL_STATS_EN
        ,
        .frame_count_o   (frame_count),
        .max_exp_o       (max_exp)
`endif
    );

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: randomized stimulus against a frame/beat-count model
// of the sequencer, exponent hold and sticky flags.
module tb_fft_frame_ctrl;

    localparam int NL = 4;
    localparam int N  = 16;
    localparam int DW = 16;
    localparam int EW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [15:0]   nframes;
    logic          abort;
    logic          in_valid;
    logic [DW-1:0] in_real;
    logic [DW-1:0] in_imag;
    logic          in_ready;
    logic          fft_sink_valid;
    logic          fft_sink_sop;
    logic          fft_sink_eop;
    logic [DW-1:0] fft_sink_real;
    logic [DW-1:0] fft_sink_imag;
    logic          fft_sink_ready;
    logic          fft_src_valid;
    logic          fft_src_sop;
    logic          fft_src_eop;
    logic [EW-1:0] fft_src_exp;
    logic [1:0]    fft_src_error;
    logic          src_ready;
    logic          fft_src_ready;
    logic [EW-1:0] exp_out;
    logic          busy;
    logic          done;
    logic          err_sticky;
    logic          exp_range_err;
`ifdef FFT_CTRL_STATS_EN
    logic [31:0]   frame_count;
    logic [EW-1:0] max_exp;
`endif

    int total = 0;
    int bad   = 0;
    int m_hold = 0;
    bit m_rng = 0;
    bit m_err = 0;
    int m_infr = 0;
    int m_outfr = 0;

    fft_frame_ctrl #(
        .NPTS_LOG2(NL),
        .DW(DW),
        .EW(EW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .nframes        (nframes),
        .abort          (abort),
        .in_valid       (in_valid),
        .in_real        (in_real),
        .in_imag        (in_imag),
        .in_ready       (in_ready),
        .fft_sink_valid (fft_sink_valid),
        .fft_sink_sop   (fft_sink_sop),
        .fft_sink_eop   (fft_sink_eop),
        .fft_sink_real  (fft_sink_real),
        .fft_sink_imag  (fft_sink_imag),
        .fft_sink_ready (fft_sink_ready),
        .fft_src_valid  (fft_src_valid),
        .fft_src_sop    (fft_src_sop),
        .fft_src_eop    (fft_src_eop),
        .fft_src_exp    (fft_src_exp),
        .fft_src_error  (fft_src_error),
        .src_ready      (src_ready),
        .fft_src_ready  (fft_src_ready),
        .exp_out        (exp_out),
        .busy           (busy),
        .done           (done),
        .err_sticky     (err_sticky),
        .exp_range_err  (exp_range_err)
`ifdef FFT_CTRL_STATS_EN
        ,
        .frame_count    (frame_count),
        .max_exp        (max_exp)
`endif
    );

    always #5 clk = ~clk;

    function automatic int roundup(input int x);
        return ((x + N - 1) / N) * N;
    endfunction

    // Input side of one run. mode 0: all ones, 1: ready toggles, 2: random.
    task automatic drive_input(input int nfr, input int abort_at,
                               input bit abort_idle, input int mode);
        int acc_n;
        int lim;
        int cyc;
        bit abt;
        bit a;
        @(negedge clk);
        nframes = nfr[15:0];
        start = 1'b1;
        abort = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        m_rng = 0;
        m_err = 0;
        m_outfr = 0;
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL start_busy got=%b want=1", busy);
        end
        total++;
        if (exp_range_err !== 1'b0 || err_sticky !== 1'b0) begin
            bad++;
            $display("FAIL start_clear rng=%b err=%b want=0/0",
                     exp_range_err, err_sticky);
        end
        acc_n = 0;
        lim = (nfr != 0) ? nfr * N : 32'h4000_0000;
        cyc = 0;
        abt = 0;
        while (acc_n < lim && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            unique case (mode)
                0: begin
                    in_valid = 1'b1;
                    fft_sink_ready = 1'b1;
                end
                1: begin
                    in_valid = 1'b1;
                    fft_sink_ready = cyc[0];
                end
                default: begin
                    in_valid = ($urandom % 4) != 0;
                    fft_sink_ready = ($urandom % 3) != 0;
                end
            endcase
            in_real = DW'($urandom);
            in_imag = DW'($urandom);
            abort = (!abt && abort_at >= 0 && acc_n == abort_at);
            if (abort && abort_idle) in_valid = 1'b0;
            #1;
            total++;
            if (in_ready !== fft_sink_ready) begin
                bad++;
                $display("FAIL in_ready beat=%0d got=%b want=%b",
                         acc_n, in_ready, fft_sink_ready);
            end
            total++;
            if (fft_sink_valid !== in_valid) begin
                bad++;
                $display("FAIL sink_valid beat=%0d got=%b want=%b",
                         acc_n, fft_sink_valid, in_valid);
            end
            if (in_valid) begin
                total++;
                if (fft_sink_sop !== (acc_n % N == 0) ||
                    fft_sink_eop !== (acc_n % N == N - 1)) begin
                    bad++;
                    $display("FAIL sop_eop beat=%0d got=%b%b want=%b%b",
                             acc_n, fft_sink_sop, fft_sink_eop,
                             (acc_n % N == 0), (acc_n % N == N - 1));
                end
                total++;
                if (fft_sink_real !== in_real || fft_sink_imag !== in_imag) begin
                    bad++;
                    $display("FAIL sink_data got=%h/%h want=%h/%h",
                             fft_sink_real, fft_sink_imag, in_real, in_imag);
                end
            end
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL done_in_run got=%b want=0", done);
            end
            a = in_valid && fft_sink_ready;
            if (abort) begin
                abt = 1;
                lim = roundup(acc_n + int'(a));
            end
            acc_n += int'(a);
        end
        total++;
        if (cyc >= 4000) begin
            bad++;
            $display("FAIL input_timeout beats=%0d want=%0d", acc_n, lim);
        end
        if (mode == 0) begin
            total++;
            if (cyc !== nfr * N) begin
                bad++;
                $display("FAIL run_cycles got=%0d want=%0d", cyc, nfr * N);
            end
        end
        m_infr = acc_n / N;
        @(negedge clk);
        abort = 1'b0;
        in_valid = 1'b1;
        fft_sink_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0 || fft_sink_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL drain_entry rdy=%b vld=%b busy=%b want=0/0/1",
                     in_ready, fft_sink_valid, busy);
        end
        in_valid = 1'b0;
    endtask

    // One output frame from the modelled FFT core with random gaps.
    task automatic src_frame(input int e, input bit inj_err);
        int k;
        int guard;
        bit a;
        logic [EW-1:0] ee;
        logic [EW-1:0] want;
        k = 0;
        guard = 0;
        ee = e[EW-1:0];
        while (k < N && guard < 500) begin
            @(negedge clk);
            guard++;
            fft_src_valid = ($urandom % 4) != 0;
            src_ready = ($urandom % 4) != 0;
            fft_src_sop = (k == 0);
            fft_src_eop = (k == N - 1);
            fft_src_exp = (fft_src_valid && k == 0) ? ee : EW'($urandom);
            if (!fft_src_valid) fft_src_error = 2'($urandom);
            else fft_src_error = (inj_err && k == 7) ? 2'd2 : 2'd0;
            #1;
            want = (fft_src_valid && k == 0) ? ee : m_hold[EW-1:0];
            total++;
            if (exp_out !== want) begin
                bad++;
                $display("FAIL exp_out k=%0d got=%0d want=%0d",
                         k, $signed(exp_out), $signed(want));
            end
            total++;
            if (fft_src_ready !== src_ready) begin
                bad++;
                $display("FAIL src_ready got=%b want=%b", fft_src_ready, src_ready);
            end
            total++;
            if (exp_range_err !== m_rng) begin
                bad++;
                $display("FAIL exp_range_err got=%b want=%b", exp_range_err, m_rng);
            end
            total++;
            if (err_sticky !== m_err) begin
                bad++;
                $display("FAIL err_sticky got=%b want=%b", err_sticky, m_err);
            end
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL done_early outfr=%0d infr=%0d got=%b",
                         m_outfr, m_infr, done);
            end
            a = fft_src_valid && src_ready;
            if (a) begin
                if (k == 0) begin
                    m_hold = e;
                    if (e < -14 || e > 2) m_rng = 1;
                end
                if (fft_src_error != 2'd0) m_err = 1;
                if (k == N - 1) m_outfr++;
                k++;
            end
        end
        total++;
        if (guard >= 500) begin
            bad++;
            $display("FAIL src_timeout beats=%0d want=%0d", k, N);
        end
    endtask

    // done pulses exactly once after the last output eop.
    task automatic check_done();
        @(negedge clk);
        fft_src_valid = 1'b0;
        fft_src_sop = 1'b0;
        fft_src_eop = 1'b0;
        src_ready = 1'b0;
        #1;
        total++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL done_pulse done=%b busy=%b want=1/1", done, busy);
        end
        @(negedge clk);
        #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_end done=%b busy=%b want=0/0", done, busy);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b1;
        fft_sink_ready = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 ||
            fft_sink_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl busy=%b done=%b rdy=%b vld=%b want=0",
                     busy, done, in_ready, fft_sink_valid);
        end
        total++;
        if (err_sticky !== 1'b0 || exp_range_err !== 1'b0 || exp_out !== '0) begin
            bad++;
            $display("FAIL reset_mon err=%b rng=%b exp=%0d want=0",
                     err_sticky, exp_range_err, exp_out);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_two_frames();
        drive_input(2, -1, 0, 0);
        src_frame(1, 0);
        src_frame(-3, 0);
        check_done();
    endtask

    task automatic test_backpressure();
        drive_input(2, -1, 0, 1);
        src_frame(0, 0);
        src_frame(2, 0);
        check_done();
    endtask

    task automatic test_exp_hold();
        drive_input(1, -1, 0, 2);
        src_frame(-3, 0);
        check_done();
    endtask

    task automatic test_exp_range();
        drive_input(2, -1, 0, 2);
        src_frame(-15, 0);
        src_frame(3, 1);
        check_done();
    endtask

    task automatic test_abort();
        drive_input(0, 2 * N + 5, 0, 2);
        total++;
        if (m_infr !== 3) begin
            bad++;
            $display("FAIL abort_frames got=%0d want=3", m_infr);
        end
        for (int i = 0; i < m_infr; i++) src_frame($urandom_range(0, 4) - 8, 0);
        check_done();
    endtask

    task automatic test_abort_boundary();
        drive_input(0, N, 1, 2);
        src_frame(-14, 0);
        check_done();
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            drive_input($urandom_range(1, 3), -1, 0, 2);
            for (int i = 0; i < m_infr; i++) begin
                src_frame($urandom_range(0, 63) - 32, $urandom_range(0, 1));
            end
            check_done();
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        nframes = 16'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        fft_sink_ready = 1'b1;
        fft_src_valid = 1'b1;
        src_ready = 1'b1;
        fft_src_sop = 1'b1;
        fft_src_exp = 6'd5;
        fft_src_error = 2'd1;
        repeat (3) @(negedge clk);
        fft_src_valid = 1'b0;
        src_ready = 1'b0;
        fft_src_error = 2'd0;
        #1;
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || err_sticky !== 1'b1 ||
            exp_range_err !== 1'b1 || exp_out !== 6'd5) begin
            bad++;
            $display("FAIL pre_reset busy=%b rdy=%b err=%b rng=%b exp=%0d want=1/1/1/1/5",
                     busy, in_ready, err_sticky, exp_range_err, exp_out);
        end
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 ||
            fft_sink_valid !== 1'b0 || fft_sink_sop !== 1'b0 ||
            fft_sink_eop !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_ctrl busy=%b done=%b rdy=%b vld=%b sop=%b eop=%b",
                     busy, done, in_ready, fft_sink_valid, fft_sink_sop, fft_sink_eop);
        end
        total++;
        if (err_sticky !== 1'b0 || exp_range_err !== 1'b0 || exp_out !== '0) begin
            bad++;
            $display("FAIL mid_reset_mon err=%b rng=%b exp=%0d want=0",
                     err_sticky, exp_range_err, exp_out);
        end
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        m_hold = 0;
        m_rng = 0;
        m_err = 0;
        drive_input(1, -1, 0, 2);
        src_frame(2, 0);
        check_done();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        nframes = 16'd0;
        abort = 1'b0;
        in_valid = 1'b0;
        in_real = '0;
        in_imag = '0;
        fft_sink_ready = 1'b0;
        fft_src_valid = 1'b0;
        fft_src_sop = 1'b0;
        fft_src_eop = 1'b0;
        fft_src_exp = '0;
        fft_src_error = 2'd0;
        src_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_two_frames();
        test_backpressure();
        test_exp_hold();
        test_exp_range();
        test_abort();
        test_abort_boundary();
        test_random();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
